// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller.
// Holds the controller state encoding and the bit-counter width helper.
package sipo_ctrl_pkg;

    // Controller states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Bits needed to count 0..w received data bits
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register datapath.
// Ports:
//   CLK   - clock, rising edge
//   RESET - synchronous active-high clear
//   EN    - shift DIN in this cycle
//   DIN   - serial data bit
//   Q     - parallel register contents
// MSB_FIRST=1 shifts left (first bit ends at Q[WIDTH-1]); 0 shifts right.
module sipo_shift_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             DIN,
    output logic [WIDTH-1:0] Q
);

    generate
        if (WIDTH == 1) begin : g_one
            always_ff @(posedge CLK) begin
                if (RESET)   Q <= '0;
                else if (EN) Q <= DIN;
            end
        end else if (MSB_FIRST) begin : g_left
            always_ff @(posedge CLK) begin
                if (RESET)   Q <= '0;
                else if (EN) Q <= {Q[WIDTH-2:0], DIN};
            end
        end else begin : g_right
            always_ff @(posedge CLK) begin
                if (RESET)   Q <= '0;
                else if (EN) Q <= {DIN, Q[WIDTH-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Fixed-length serial frame receiver: sequences a SIPO shift register and
// presents each completed word on DOUT with a VALID/READY handshake.
// Ports:
//   CLK, RESET     - clock and synchronous active-high reset
//   START, DIN     - frame start strobe (bit 0 on DIN same cycle), serial data
//   READY          - consumer accepts DOUT when VALID & READY
//   DOUT, VALID    - received word and its valid flag (registered)
//   BUSY           - frame reception in progress
//   OVERRUN        - sticky: a start was refused while a word was unconsumed
//   PAR_ERR        - even-parity error for the current DOUT
// Build option: define PARITY_CHECK_EN to receive one extra even-parity bit per
// frame; without it PAR_ERR stays 0 and frames are WIDTH bits long.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             DIN,
    input  logic             READY,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic             PAR_ERR
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // State after capturing bit 0, and after the last data bit in SHIFT
    localparam state_t FIRST_ST = (WIDTH == 1) ? (PAR_EN ? ST_PARITY : ST_HOLD) : ST_SHIFT;
    localparam state_t DONE_ST  = PAR_EN ? ST_PARITY : ST_HOLD;

    state_t           state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH-1:0] q, word_c;
    logic [WIDTH-1:0] dout_nxt;
    logic             valid_nxt, busy_nxt, ovr_nxt, par_nxt;
    logic             en_c, start_ok_c, last_c;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (en_c),
        .DIN   (DIN),
        .Q     (q)
    );

    // Word as it will look once the bit on DIN is shifted in
    generate
        if (WIDTH == 1) begin : g_w1
            assign word_c = DIN;
        end else if (MSB_FIRST) begin : g_wl
            assign word_c = {q[WIDTH-2:0], DIN};
        end else begin : g_wr
            assign word_c = {DIN, q[WIDTH-1:1]};
        end
    endgenerate

    // A new frame may start from IDLE, or from HOLD when the word is consumed
    assign start_ok_c = START && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && READY));
    assign last_c     = (cnt_q == CW'(WIDTH - 1));

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            DOUT    <= '0;
            VALID   <= 1'b0;
            BUSY    <= 1'b0;
            OVERRUN <= 1'b0;
            PAR_ERR <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            DOUT    <= dout_nxt;
            VALID   <= valid_nxt;
            BUSY    <= busy_nxt;
            OVERRUN <= ovr_nxt;
            PAR_ERR <= par_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok_c) state_nxt = FIRST_ST;
            ST_SHIFT:  if (last_c) state_nxt = DONE_ST;
            ST_PARITY: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (start_ok_c) state_nxt = FIRST_ST;
                else if (READY) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath control and next values of the registered outputs
    always_comb begin
        en_c      = 1'b0;
        cnt_nxt   = cnt_q;
        dout_nxt  = DOUT;
        valid_nxt = VALID;
        ovr_nxt   = OVERRUN;
        par_nxt   = PAR_ERR;
        busy_nxt  = (state_nxt == ST_SHIFT) || (state_nxt == ST_PARITY);
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_ok_c) begin
                    en_c      = 1'b1;
                    cnt_nxt   = CW'(1);
                    valid_nxt = 1'b0;
                    if (FIRST_ST == ST_HOLD) begin
                        dout_nxt  = word_c;
                        valid_nxt = 1'b1;
                    end
                end else if (state_q == ST_HOLD) begin
                    if (READY)      valid_nxt = 1'b0;
                    else if (START) ovr_nxt   = 1'b1;
                end
            end
            ST_SHIFT: begin
                en_c    = 1'b1;
                cnt_nxt = cnt_q + CW'(1);
                if (last_c) begin
                    cnt_nxt = '0;
                    if (!PAR_EN) begin
                        dout_nxt  = word_c;
                        valid_nxt = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                // Data is already complete in the shift register; DIN is the parity bit
                dout_nxt  = q;
                par_nxt   = ^{q, DIN};
                valid_nxt = 1'b1;
                cnt_nxt   = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: MSB-first and LSB-first instances
// share stimulus and are compared every cycle against a frame-level model.
module tb_sipo_frame_ctrl;

    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int L   = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int L   = W;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, din, ready;
    logic [W-1:0] dout_m, dout_l;
    logic valid_m, busy_m, ovr_m, perr_m;
    logic valid_l, busy_l, ovr_l, perr_l;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit           m_recv;
    int           bits[$];
    logic [W-1:0] e_msb, e_lsb;
    bit           e_valid, e_ovr, e_perr;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RESET(reset), .START(start), .DIN(din), .READY(ready),
        .DOUT(dout_m), .VALID(valid_m), .BUSY(busy_m), .OVERRUN(ovr_m), .PAR_ERR(perr_m)
    );

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RESET(reset), .START(start), .DIN(din), .READY(ready),
        .DOUT(dout_l), .VALID(valid_l), .BUSY(busy_l), .OVERRUN(ovr_l), .PAR_ERR(perr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame finished: build both bit orders and the parity result from the bit list
    task automatic model_complete();
        bit p;
        e_msb = '0;
        e_lsb = '0;
        p     = 1'b0;
        for (int i = 0; i < W; i++) begin
            e_msb[W-1-i] = bits[i][0];
            e_lsb[i]     = bits[i][0];
        end
        for (int i = 0; i < L; i++) p ^= bits[i][0];
        e_perr  = PAR ? p : 1'b0;
        e_valid = 1'b1;
        m_recv  = 1'b0;
        bits.delete();
    endtask

    task automatic model_begin(input bit d);
        bits.delete();
        bits.push_back(int'(d));
        m_recv = 1'b1;
        if (bits.size() == L) model_complete();
    endtask

    task automatic model_edge(input bit r, input bit s, input bit d, input bit rdy);
        if (r) begin
            m_recv = 1'b0; bits.delete();
            e_msb = '0; e_lsb = '0;
            e_valid = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;
        end else if (m_recv) begin
            bits.push_back(int'(d));
            if (bits.size() == L) model_complete();
        end else if (e_valid) begin
            if (rdy) begin
                e_valid = 1'b0;
                if (s) model_begin(d);
            end else if (s) begin
                e_ovr = 1'b1;
            end
        end else if (s) begin
            model_begin(d);
        end
    endtask

    task automatic check_all();
        chk("dout_msb", 32'(dout_m), 32'(e_msb));
        chk("dout_lsb", 32'(dout_l), 32'(e_lsb));
        chk("valid",    32'(valid_m), 32'(e_valid));
        chk("valid_l",  32'(valid_l), 32'(e_valid));
        chk("busy",     32'(busy_m),  32'(m_recv));
        chk("busy_l",   32'(busy_l),  32'(m_recv));
        chk("overrun",  32'(ovr_m),   32'(e_ovr));
        chk("par_err",  32'(perr_m),  32'(e_perr));
    endtask

    task automatic step(input bit r, input bit s, input bit d, input bit rdy);
        reset = r; start = s; din = d; ready = rdy;
        @(posedge clk);
        model_edge(r, s, d, rdy);
        #1;
        check_all();
    endtask

    // One full frame: b[W-1] is sent first; the parity bit only in parity builds
    task automatic send(input logic [W-1:0] b, input bit pbit, input bit rdy);
        for (int i = 0; i < W; i++) step(1'b0, i == 0, b[W-1-i], rdy);
        if (PAR) step(1'b0, 1'b0, pbit, rdy);
    endtask

    initial begin
        m_recv = 1'b0; e_msb = '0; e_lsb = '0;
        e_valid = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;

        // Reset dominates START/DIN
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_dout",  32'(dout_m), 32'h0);
        chk("rst_valid", 32'(valid_m), 32'h0);
        chk("rst_busy",  32'(busy_m), 32'h0);
        chk("rst_ovr",   32'(ovr_m), 32'h0);
        chk("rst_perr",  32'(perr_m), 32'h0);

        // Basic frame 1,0,0,1 with READY high
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("basic_busy0", 32'(busy_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        if (PAR) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_valid", 32'(valid_m), 32'h1);
        chk("basic_dout",  32'(dout_m), 32'h9);
        chk("basic_idle",  32'(busy_m), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_consumed", 32'(valid_m), 32'h0);

        // Backpressure, then a refused start sets the sticky overrun
        send(4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_valid", 32'(valid_m), 32'h1);
        chk("bp_dout",  32'(dout_m), 32'h9);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovr_set",  32'(ovr_m), 32'h1);
        chk("ovr_dout", 32'(dout_m), 32'h9);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drop_valid", 32'(valid_m), 32'h0);
        chk("ovr_sticky",     32'(ovr_m), 32'h1);

        // Back-to-back frames: consume and restart on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(4'b1001, 1'b0, 1'b1);
        send(4'b0110, 1'b0, 1'b1);
        chk("b2b_dout",  32'(dout_m), 32'h6);
        chk("b2b_valid", 32'(valid_m), 32'h1);
        chk("b2b_ovr",   32'(ovr_m), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset after two bits discards the partial frame
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("abort_busy",  32'(busy_m), 32'h0);
        chk("abort_valid", 32'(valid_m), 32'h0);
        send(4'b1111, 1'b0, 1'b1);
        chk("abort_dout", 32'(dout_m), 32'hF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first ordering: first bit 1 lands in DOUT[0]
        send(4'b1000, 1'b1, 1'b1);
        chk("lsb_dout", 32'(dout_l), 32'h1);
        chk("msb_dout", 32'(dout_m), 32'h8);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Parity bit 1 on data 1001 is an error, parity bit 0 is not
        send(4'b1001, 1'b1, 1'b1);
        chk("par_err_1", 32'(perr_m), PAR ? 32'h1 : 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(4'b1001, 1'b0, 1'b1);
        chk("par_err_0", 32'(perr_m), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
